// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake and reg_alu control bus for alu_sequencer
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [15:0]           instr;
    logic [DATA_WIDTH-1:0] instr_data;
    logic                  cout;
    logic                  s;
    logic                  wr;
    logic [1:0]            operation;
    logic [2:0]            rd_addr_a;
    logic [2:0]            rd_addr_b;
    logic [2:0]            wr_addr;
    logic [DATA_WIDTH-1:0] d_in;
    logic                  carry_flag;
    logic                  busy;
    logic                  done;

    // Upstream instruction source and reg_alu side
    modport master (
        output instr_valid, instr, instr_data, cout,
        input  instr_ready, s, wr, operation, rd_addr_a, rd_addr_b,
               wr_addr, d_in, carry_flag, busy, done
    );

    // Sequencer side
    modport slave (
        input  instr_valid, instr, instr_data, cout,
        output instr_ready, s, wr, operation, rd_addr_a, rd_addr_b,
               wr_addr, d_in, carry_flag, busy, done
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving the reg_alu register-file/ALU datapath
module alu_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    localparam logic [1:0] K_NOP   = 2'b00;
    localparam logic [1:0] K_LOADI = 2'b01;
    localparam logic [1:0] K_RPT   = 2'b11;

    state_t                r_state;
    logic [2:0]            r_count;
    logic                  r_alu_kind;
    logic                  r_s;
    logic                  r_wr;
    logic [1:0]            r_operation;
    logic [2:0]            r_rd_addr_a;
    logic [2:0]            r_rd_addr_b;
    logic [2:0]            r_wr_addr;
    logic [DATA_WIDTH-1:0] r_d_in;
    logic                  r_carry_flag;
    logic                  r_busy;
    logic                  r_done;

    logic [1:0]            w_kind;
    assign w_kind = bus.instr[15:14];

    // Ready is gated by reset so it reads 0 while reset is held low
    assign bus.instr_ready = reset && (r_state == S_IDLE);
    assign bus.s           = r_s;
    assign bus.wr          = r_wr;
    assign bus.operation   = r_operation;
    assign bus.rd_addr_a   = r_rd_addr_a;
    assign bus.rd_addr_b   = r_rd_addr_b;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.d_in        = r_d_in;
    assign bus.carry_flag  = r_carry_flag;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    // Control FSM: latch an instruction in IDLE, issue one write per EXEC cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= 3'd0;
            r_alu_kind   <= 1'b0;
            r_s          <= 1'b0;
            r_wr         <= 1'b0;
            r_operation  <= 2'd0;
            r_rd_addr_a  <= 3'd0;
            r_rd_addr_b  <= 3'd0;
            r_wr_addr    <= 3'd0;
            r_d_in       <= '0;
            r_carry_flag <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // NOP completes the handshake but leaves everything untouched
                    if (bus.instr_valid && (w_kind != K_NOP)) begin
                        r_alu_kind  <= (w_kind != K_LOADI);
                        r_s         <= (w_kind == K_LOADI);
                        r_operation <= bus.instr[13:12];
                        r_wr_addr   <= bus.instr[11:9];
                        r_rd_addr_a <= bus.instr[8:6];
                        r_rd_addr_b <= bus.instr[5:3];
                        r_d_in      <= bus.instr_data;
                        r_count     <= (w_kind == K_RPT) ? bus.instr[2:0] : 3'd0;
                        r_wr        <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // reg_alu writes on this edge; carry reflects the ALU result being written
                    if (r_alu_kind) begin
                        r_carry_flag <= bus.cout;
                    end
                    if (r_count != 3'd0) begin
                        r_count <= r_count - 3'd1;
                    end else begin
                        r_wr    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a reg_alu model
module tb_alu_sequencer;
    localparam logic [1:0] K_NOP   = 2'b00;
    localparam logic [1:0] K_LOADI = 2'b01;
    localparam logic [1:0] K_ALU   = 2'b10;
    localparam logic [1:0] K_RPT   = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_WIDTH(16)) u_if ();

    alu_sequencer #(.DATA_WIDTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    // reg_alu model: 8x16 register file with combinational ALU
    logic [15:0] regs [8] = '{default: 16'h0000};
    logic [16:0] alu_res;
    always_comb begin
        alu_res = 17'h0;
        case (u_if.operation)
            2'b00: alu_res = {1'b0, regs[u_if.rd_addr_a]} + {1'b0, regs[u_if.rd_addr_b]};
            2'b01: alu_res = {1'b0, regs[u_if.rd_addr_a] - regs[u_if.rd_addr_b]};
            2'b10: alu_res = {1'b0, regs[u_if.rd_addr_a] & regs[u_if.rd_addr_b]};
            default: alu_res = {1'b0, regs[u_if.rd_addr_a] | regs[u_if.rd_addr_b]};
        endcase
    end
    assign u_if.cout = alu_res[16];

    always @(posedge clk) begin
        if (u_if.wr) begin
            regs[u_if.wr_addr] <= u_if.s ? u_if.d_in : alu_res[15:0];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] enc(input logic [1:0] k, input logic [1:0] op,
                                        input logic [2:0] d, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
        return {k, op, d, a, b, c};
    endfunction

    // Present an instruction and return just after the accepting edge
    task automatic issue(input logic [15:0] ins, input logic [15:0] dat);
        @(negedge clk);
        u_if.instr       = ins;
        u_if.instr_data  = dat;
        u_if.instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (u_if.instr_ready) break;
            @(negedge clk);
        end
        if (!u_if.instr_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            u_if.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        u_if.instr_valid = 1'b0;
    endtask

    // Count wr/busy/done over a window of cycles, sampled on falling edges
    task automatic observe(input int ncyc, output int nwr, output int nbusy, output int ndone);
        nwr = 0; nbusy = 0; ndone = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (u_if.wr)   nwr++;
            if (u_if.busy) nbusy++;
            if (u_if.done) ndone++;
        end
    endtask

    int nwr, nbusy, ndone, nwait, nbad;

    initial begin
        u_if.instr_valid = 1'b0;
        u_if.instr       = 16'h0000;
        u_if.instr_data  = 16'h0000;

        // Reset state
        #12;
        check("rst_ready", u_if.instr_ready, 1'b0);
        check("rst_wr",    u_if.wr, 1'b0);
        check("rst_busy",  u_if.busy, 1'b0);
        check("rst_done",  u_if.done, 1'b0);
        check("rst_carry", u_if.carry_flag, 1'b0);
        check("rst_din",   u_if.d_in, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ready", u_if.instr_ready, 1'b1);

        // LOADI R2 = 0x1234 with cycle-exact output checks
        issue(enc(K_LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'h1234);
        @(negedge clk);
        check("ld_wr",    u_if.wr, 1'b1);
        check("ld_s",     u_if.s, 1'b1);
        check("ld_waddr", u_if.wr_addr, 3'd2);
        check("ld_din",   u_if.d_in, 16'h1234);
        check("ld_ready", u_if.instr_ready, 1'b0);
        check("ld_busy",  u_if.busy, 1'b1);
        @(negedge clk);
        check("ld_wr_off", u_if.wr, 1'b0);
        check("ld_done",   u_if.done, 1'b1);
        check("ld_ready1", u_if.instr_ready, 1'b1);
        @(negedge clk);
        check("ld_done_off", u_if.done, 1'b0);
        check("ld_r2", regs[2], 16'h1234);

        // 5 + 3 = 8, no carry; LOADI cnt bits are ignored
        issue(enc(K_LOADI, 2'b00, 3'd1, 3'd0, 3'd0, 3'd7), 16'd5);
        observe(3, nwr, nbusy, ndone);
        check("ld_cnt_ignored_wr", nwr, 1);
        issue(enc(K_LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'd3);
        issue(enc(K_ALU, 2'b00, 3'd3, 3'd1, 3'd2, 3'd5), 16'h0000);
        observe(4, nwr, nbusy, ndone);
        check("add_nwr", nwr, 1);
        check("add_r3", regs[3], 16'd8);
        check("add_carry", u_if.carry_flag, 1'b0);

        // 1 + 0xFFFF = 0 with carry
        issue(enc(K_LOADI, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'd1);
        issue(enc(K_LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'hFFFF);
        issue(enc(K_ALU, 2'b00, 3'd4, 3'd1, 3'd2, 3'd0), 16'h0000);
        observe(3, nwr, nbusy, ndone);
        check("carry_r4", regs[4], 16'h0000);
        check("carry_set", u_if.carry_flag, 1'b1);

        // RPT add cnt=3 accumulating into R1: 0 + 4*3 = 12; LOADI leaves carry alone
        issue(enc(K_LOADI, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'd0);
        issue(enc(K_LOADI, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'd3);
        observe(2, nwr, nbusy, ndone);
        check("loadi_keeps_carry", u_if.carry_flag, 1'b1);
        issue(enc(K_RPT, 2'b00, 3'd1, 3'd1, 3'd2, 3'd3), 16'h0000);
        observe(10, nwr, nbusy, ndone);
        check("rpt_nwr", nwr, 4);
        check("rpt_nbusy", nbusy, 4);
        check("rpt_ndone", ndone, 1);
        check("rpt_r1", regs[1], 16'd12);
        check("rpt_carry", u_if.carry_flag, 1'b0);

        // cnt=7 gives exactly 8 writes: R0 = 8*3 = 24
        issue(enc(K_RPT, 2'b00, 3'd0, 3'd0, 3'd2, 3'd7), 16'h0000);
        observe(12, nwr, nbusy, ndone);
        check("rpt8_nwr", nwr, 8);
        check("rpt8_ndone", ndone, 1);
        check("rpt8_r0", regs[0], 16'd24);

        // NOP with valid held: no write, no done, stays ready
        @(negedge clk);
        u_if.instr       = enc(K_NOP, 2'b00, 3'd6, 3'd0, 3'd0, 3'd0);
        u_if.instr_valid = 1'b1;
        observe(4, nwr, nbusy, ndone);
        check("nop_nwr", nwr, 0);
        check("nop_ndone", ndone, 0);
        check("nop_nbusy", nbusy, 0);
        check("nop_ready", u_if.instr_ready, 1'b1);
        u_if.instr_valid = 1'b0;

        // Instruction held while busy is not taken until ready returns: R5 = 3*3 = 9
        issue(enc(K_RPT, 2'b00, 3'd5, 3'd5, 3'd2, 3'd2), 16'h0000);
        u_if.instr       = enc(K_LOADI, 2'b00, 3'd6, 3'd0, 3'd0, 3'd0);
        u_if.instr_data  = 16'hABCD;
        u_if.instr_valid = 1'b1;
        nwait = 0; nbad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.instr_ready) break;
            nwait++;
            if (u_if.wr_addr == 3'd6) nbad++;
        end
        if (u_if.instr_ready) begin
            @(posedge clk);
            #1;
        end
        u_if.instr_valid = 1'b0;
        check("busy_wait_cycles", nwait, 3);
        check("busy_no_early", nbad, 0);
        observe(3, nwr, nbusy, ndone);
        check("busy_r5", regs[5], 16'd9);
        check("busy_r6", regs[6], 16'hABCD);

        // Reset in the 2nd cycle of RPT cnt=5: one write done, rest aborted
        issue(enc(K_RPT, 2'b00, 3'd7, 3'd7, 3'd2, 3'd5), 16'h5A5A);
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_wr", u_if.wr, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_wr",    u_if.wr, 1'b0);
        check("abort_busy",  u_if.busy, 1'b0);
        check("abort_ready", u_if.instr_ready, 1'b0);
        check("abort_din",   u_if.d_in, 16'h0);
        check("abort_waddr", u_if.wr_addr, 3'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rel_ready", u_if.instr_ready, 1'b1);
        observe(6, nwr, nbusy, ndone);
        check("abort_no_wr", nwr, 0);
        check("abort_no_done", ndone, 0);
        check("abort_r7", regs[7], 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
